uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side buffer between uart_rx and the UART/data-memory bridge logic.
- Detects each rising edge of the uart_rx ready flag and captures the received byte into a first-word-fall-through FIFO, so the CPU no longer loses bytes that arrive faster than it polls.
- Exposes a pop interface, occupancy, a sticky overrun flag, a saturating drop counter and a packed 16-bit status word that the bridge writes to the UART status address.

Parameters:
DEPTH, 16, number of byte entries; must be a power of two, minimum 2
ADDR_WIDTH, 4, log2(DEPTH); pointer width
DROP_WIDTH, 8, width of the saturating dropped-byte counter

Ports:
clock  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
rx_ready  input  1  ready level from uart_rx; a 0->1 transition marks a new byte
rx_data  input  8  received byte from uart_rx; valid when rx_ready rises
pop  input  1  consume head entry; one entry per cycle while high
clear  input  1  synchronous flush of FIFO contents and error state
dout  output  8  head entry (first-word-fall-through); 8'h00 when empty
valid  output  1  FIFO not empty
full  output  1  count == DEPTH
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overrun  output  1  sticky: at least one byte dropped since the last reset or clear
drop_count  output  DROP_WIDTH  number of dropped bytes, saturating at all-ones
status  output  16  {8'b0, drop_count!=0, overrun, full, valid, 4'b0}

Behaviour:
- Reset (asynchronous, active-high), and the same state while rst is held:
  - wr_ptr=0, rd_ptr=0, count=0, overrun=0, drop_count=0.
  - prev_ready=1, so an rx_ready already high on reset release is not a push.
  - Outputs: valid=0, full=0, dout=0, status=16'h0000. Storage contents are don't-care.
- Push event:
  - push = rx_ready & ~prev_ready.
  - prev_ready <= rx_ready every cycle, independent of push or clear.
  - rx_data is sampled in the edge cycle.
- Push accepted when count<DEPTH, or when count==DEPTH and an effective pop occurs in the same cycle.
  - mem[wr_ptr] <= rx_data; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Push refused when full with no pop:
  - Data is discarded and wr_ptr is unchanged.
  - overrun <= 1.
  - drop_count <= drop_count+1, held at all-ones once saturated.
- Effective pop = pop & valid. It advances rd_ptr modulo DEPTH. pop while empty is ignored, with no error.
- count update:
  - +1 on accepted push only.
  - -1 on effective pop only.
  - Unchanged when both occur or neither occurs.
- Latency: a byte pushed in cycle N appears on dout with valid=1 in cycle N+1. Pushing into an empty FIFO with pop in the same cycle does not bypass; the pop is ignored.
- dout = mem[rd_ptr] when valid, otherwise 0. It is combinational from registered state and changes in the cycle after an effective pop.
- clear has priority over push and pop in the same cycle:
  - Pointers, count, overrun and drop_count go to 0.
  - A push edge coinciding with clear is discarded without setting overrun.
- full, valid and status derive combinationally from registered count, overrun and drop_count; there are no extra pipeline stages.
- No internal state machine beyond the pointer/count datapath. Edge detect plus FIFO is the only sequential logic.

Test Plan:
- Reset released with rx_ready held 1 -> no push; count=0, valid=0, status=16'h0000. Then rx_ready 0->1 with rx_data=8'hA5 -> next cycle valid=1, dout=8'hA5, count=1, status=16'h0010.
- Push 8'h01..8'h10 (16 bytes) with no pop -> full=1, count=16, status=16'h0030. Pop 16 times -> dout reads 8'h01..8'h10 in order, wrap correct, valid=0 after the last pop.
- Full FIFO, push 8'hEE without pop -> 8'hEE absent from the output, overrun=1, drop_count=1, status=16'h00F0. Then 300 further drops -> drop_count=8'hFF, no wrap.
- Full FIFO, push 8'h77 coinciding with pop -> count stays 16, overrun stays 0, 8'h77 is the 16th byte read out.
- Empty FIFO, pop pulses -> count stays 0, no underflow. Push edge coinciding with clear when count=5 and overrun=1 -> count=0, overrun=0, drop_count=0, byte discarded.
- Assert rst mid-stream with count=7 -> all outputs return to reset values immediately (asynchronous). After release, a new edge with 8'h3C -> count=1, dout=8'h3C.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Bundle of the receive-FIFO signals shared by the byte source/consumer side
// and the FIFO itself.
//
// Handshake: rx_ready is a level from uart_rx; only its 0->1 transition
// offers a byte (rx_data valid in that edge cycle), and there is no
// backpressure toward the receiver. On the read side, valid is the FIFO's
// "data available" flag and pop is the consumer's request; a transfer
// happens only in a cycle where pop && valid, and dout is the head byte
// presented whenever valid is high.
interface uart_rx_fifo_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DROP_WIDTH = 8
);
    logic                  rx_ready;
    logic [7:0]            rx_data;
    logic                  pop;
    logic                  clear;
    logic [7:0]            dout;
    logic                  valid;
    logic                  full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overrun;
    logic [DROP_WIDTH-1:0] drop_count;
    logic [15:0]           status;

    // Side that feeds bytes in and consumes them (bridge / testbench).
    modport master (
        output rx_ready, rx_data, pop, clear,
        input  dout, valid, full, count, overrun, drop_count, status
    );

    // The FIFO itself.
    modport slave (
        input  rx_ready, rx_data, pop, clear,
        output dout, valid, full, count, overrun, drop_count, status
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: edge-detects the uart_rx ready level, captures
// each new byte into a first-word-fall-through FIFO, and reports occupancy,
// a sticky overrun flag, a saturating drop counter and a packed status word.
module uart_rx_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DROP_WIDTH = 8
) (
    input  logic            clock,
    input  logic            rst,
    uart_rx_fifo_if.slave   bus
);
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

    logic                  r_prev_ready;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overrun;
    logic [DROP_WIDTH-1:0] r_drop_count;
    logic [7:0]            r_mem [DEPTH];

    logic w_push;
    logic w_valid;
    logic w_full;
    logic w_pop;
    logic w_accept;
    logic w_drop;

    // A byte is offered only on the rising edge of the ready level. A full
    // FIFO still accepts it when the head is popped in the same cycle,
    // because that pop frees the slot being written.
    assign w_push   = bus.rx_ready & ~r_prev_ready;
    assign w_valid  = (r_count != '0);
    assign w_full   = (r_count == C_DEPTH);
    assign w_pop    = bus.pop & w_valid;
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;

    // Edge-detect history; reset to 1 so a level already high at reset
    // release is not mistaken for a new byte.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_prev_ready <= 1'b1;
        end else begin
            r_prev_ready <= bus.rx_ready;
        end
    end

    // Pointer, occupancy and error bookkeeping; clear wins over push/pop.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overrun    <= 1'b0;
            r_drop_count <= '0;
        end else if (bus.clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overrun    <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + (ADDR_WIDTH+1)'(1);
            end else if (w_pop && !w_accept) begin
                r_count <= r_count - (ADDR_WIDTH+1)'(1);
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + DROP_WIDTH'(1);
                end
            end
        end
    end

    // Byte storage; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (w_accept && !bus.clear) begin
            r_mem[r_wr_ptr] <= bus.rx_data;
        end
    end

    assign bus.dout       = w_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign bus.valid      = w_valid;
    assign bus.full       = w_full;
    assign bus.count      = r_count;
    assign bus.overrun    = r_overrun;
    assign bus.drop_count = r_drop_count;
    assign bus.status     = {8'b0, (r_drop_count != '0), r_overrun, w_full, w_valid, 4'b0};
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reset, fill/drain with wrap, overrun and
// drop-counter saturation, push-with-pop at full, empty pops, clear
// priority and asynchronous reset mid-stream.
module tb_uart_rx_fifo;
    logic clock;
    logic rst;
    int   n_vec;
    int   n_err;

    uart_rx_fifo_if #(.ADDR_WIDTH(4), .DROP_WIDTH(8)) bus ();

    uart_rx_fifo #(.DEPTH(16), .ADDR_WIDTH(4), .DROP_WIDTH(8)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    // Clock generation: 10 ns period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; inputs set before the call are sampled at the edge
    // and outputs are read 1 ns after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Driver: one ready rising edge carrying byte b, then ready back low.
    task automatic push_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.rx_ready = 1'b1;
        bus.rx_data  = 8'h5A;
        bus.pop      = 1'b0;
        bus.clear    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_vec++;
        if (bus.count !== 5'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        n_vec++;
        if (bus.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
        n_vec++;
        if (bus.status !== 16'h0000) begin n_err++; $display("FAIL reset_status got=%h exp=0000", bus.status); end
        n_vec++;
        if (bus.dout !== 8'h00) begin n_err++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
        bus.rx_ready = 1'b0;
        tick();
        bus.rx_data  = 8'hA5;
        bus.rx_ready = 1'b1;
        tick();
        n_vec++;
        if (bus.valid !== 1'b1 || bus.dout !== 8'hA5) begin
            n_err++; $display("FAIL first_push valid=%b dout=%h exp valid=1 dout=a5", bus.valid, bus.dout);
        end
        n_vec++;
        if (bus.count !== 5'd1) begin n_err++; $display("FAIL first_push_count got=%0d exp=1", bus.count); end
        n_vec++;
        if (bus.status !== 16'h0010) begin n_err++; $display("FAIL first_push_status got=%h exp=0010", bus.status); end
        bus.rx_ready = 1'b0;
        tick();
        pop_one();
        n_vec++;
        if (bus.valid !== 1'b0) begin n_err++; $display("FAIL first_pop_valid got=%b exp=0", bus.valid); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) push_byte(8'(i));
        n_vec++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
            n_err++; $display("FAIL fill full=%b count=%0d exp full=1 count=16", bus.full, bus.count);
        end
        n_vec++;
        if (bus.status !== 16'h0030) begin n_err++; $display("FAIL fill_status got=%h exp=0030", bus.status); end
        for (int i = 1; i <= 16; i++) begin
            n_vec++;
            if (bus.dout !== 8'(i)) begin n_err++; $display("FAIL drain_%0d got=%h exp=%h", i, bus.dout, 8'(i)); end
            pop_one();
        end
        n_vec++;
        if (bus.valid !== 1'b0 || bus.count !== 5'd0) begin
            n_err++; $display("FAIL drain_empty valid=%b count=%0d exp valid=0 count=0", bus.valid, bus.count);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
        push_byte(8'hEE);
        n_vec++;
        if (bus.overrun !== 1'b1 || bus.drop_count !== 8'd1) begin
            n_err++; $display("FAIL drop_one overrun=%b drop=%0d exp overrun=1 drop=1", bus.overrun, bus.drop_count);
        end
        n_vec++;
        if (bus.status !== 16'h00F0 || bus.count !== 5'd16) begin
            n_err++; $display("FAIL drop_status status=%h count=%0d exp status=00f0 count=16", bus.status, bus.count);
        end
        for (int i = 0; i < 300; i++) push_byte(8'(i));
        n_vec++;
        if (bus.drop_count !== 8'hFF) begin n_err++; $display("FAIL drop_saturate got=%h exp=ff", bus.drop_count); end
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (bus.dout !== 8'h20 + 8'(i)) begin
                n_err++; $display("FAIL overrun_drain_%0d got=%h exp=%h", i, bus.dout, 8'h20 + 8'(i));
            end
            pop_one();
        end
        n_vec++;
        if (bus.valid !== 1'b0 || bus.overrun !== 1'b1) begin
            n_err++; $display("FAIL overrun_sticky valid=%b overrun=%b exp valid=0 overrun=1", bus.valid, bus.overrun);
        end
        do_clear();
        n_vec++;
        if (bus.overrun !== 1'b0 || bus.drop_count !== 8'd0 || bus.status !== 16'h0000) begin
            n_err++; $display("FAIL clear_errors overrun=%b drop=%0d status=%h exp 0/0/0000",
                              bus.overrun, bus.drop_count, bus.status);
        end
    endtask

    task automatic test_push_with_pop();
        logic [7:0] exp_q[$];
        for (int i = 0; i < 16; i++) begin
            push_byte(8'h40 + 8'(i));
            exp_q.push_back(8'h40 + 8'(i));
        end
        bus.rx_data  = 8'h77;
        bus.rx_ready = 1'b1;
        bus.pop      = 1'b1;
        tick();
        bus.pop      = 1'b0;
        bus.rx_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h77);
        tick();
        n_vec++;
        if (bus.count !== 5'd16 || bus.overrun !== 1'b0) begin
            n_err++; $display("FAIL full_push_pop count=%0d overrun=%b exp count=16 overrun=0", bus.count, bus.overrun);
        end
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (bus.dout !== exp_q[i]) begin
                n_err++; $display("FAIL push_pop_read_%0d got=%h exp=%h", i, bus.dout, exp_q[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_empty_pop();
        for (int i = 0; i < 3; i++) pop_one();
        n_vec++;
        if (bus.count !== 5'd0 || bus.valid !== 1'b0 || bus.dout !== 8'h00) begin
            n_err++; $display("FAIL empty_pop count=%0d valid=%b dout=%h exp 0/0/00", bus.count, bus.valid, bus.dout);
        end
        bus.rx_data  = 8'h5C;
        bus.rx_ready = 1'b1;
        bus.pop      = 1'b1;
        tick();
        bus.pop      = 1'b0;
        bus.rx_ready = 1'b0;
        tick();
        n_vec++;
        if (bus.count !== 5'd1 || bus.dout !== 8'h5C) begin
            n_err++; $display("FAIL empty_push_pop count=%0d dout=%h exp count=1 dout=5c", bus.count, bus.dout);
        end
        do_clear();
    endtask

    task automatic test_clear_collision();
        for (int i = 0; i < 17; i++) push_byte(8'h60 + 8'(i));
        for (int i = 0; i < 11; i++) pop_one();
        n_vec++;
        if (bus.count !== 5'd5 || bus.overrun !== 1'b1) begin
            n_err++; $display("FAIL pre_clear count=%0d overrun=%b exp count=5 overrun=1", bus.count, bus.overrun);
        end
        bus.rx_data  = 8'h99;
        bus.rx_ready = 1'b1;
        bus.clear    = 1'b1;
        tick();
        bus.clear    = 1'b0;
        bus.rx_ready = 1'b0;
        tick();
        n_vec++;
        if (bus.count !== 5'd0 || bus.overrun !== 1'b0 || bus.drop_count !== 8'd0 || bus.valid !== 1'b0) begin
            n_err++; $display("FAIL clear_push count=%0d overrun=%b drop=%0d valid=%b exp all 0",
                              bus.count, bus.overrun, bus.drop_count, bus.valid);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) push_byte(8'h80 + 8'(i));
        n_vec++;
        if (bus.count !== 5'd7) begin n_err++; $display("FAIL pre_reset_count got=%0d exp=7", bus.count); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.count !== 5'd0 || bus.valid !== 1'b0 || bus.dout !== 8'h00 || bus.status !== 16'h0000) begin
            n_err++; $display("FAIL async_reset count=%0d valid=%b dout=%h status=%h exp 0/0/00/0000",
                              bus.count, bus.valid, bus.dout, bus.status);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        push_byte(8'h3C);
        n_vec++;
        if (bus.count !== 5'd1 || bus.dout !== 8'h3C) begin
            n_err++; $display("FAIL post_reset_push count=%0d dout=%h exp count=1 dout=3c", bus.count, bus.dout);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_fill_drain();
        test_overrun();
        test_push_with_pop();
        test_empty_pop();
        test_clear_collision();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
